// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-buffered UART transmitter with configurable data width,
// runtime parity mode, one or two stop bits and a 16x baud-tick timebase
// shared with the companion receiver's 8-entry baud_select table.
module uart_tx_fifo #(
    parameter int CLK_HZ     = 50000000,
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                        Clk,
    input  logic                        reset,
    input  logic [2:0]                  baud_select,
    input  logic [1:0]                  parity_mode,
    input  logic                        two_stop,
    input  logic                        Tx_EN,
    input  logic                        Tx_WR,
    input  logic [DATA_WIDTH-1:0]       Tx_DATA,
    output logic                        TxD,
    output logic                        Tx_BUSY,
    output logic                        Tx_FULL,
    output logic                        Tx_EMPTY,
    output logic [$clog2(FIFO_DEPTH):0] Tx_LEVEL,
    output logic                        Tx_OVERFLOW
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    // Rounded divisors: one baud tick every D cycles, 16 ticks per bit.
    localparam int DIV_0 = (CLK_HZ + 8 * 300)    / (16 * 300);
    localparam int DIV_1 = (CLK_HZ + 8 * 1200)   / (16 * 1200);
    localparam int DIV_2 = (CLK_HZ + 8 * 4800)   / (16 * 4800);
    localparam int DIV_3 = (CLK_HZ + 8 * 9600)   / (16 * 9600);
    localparam int DIV_4 = (CLK_HZ + 8 * 19200)  / (16 * 19200);
    localparam int DIV_5 = (CLK_HZ + 8 * 38400)  / (16 * 38400);
    localparam int DIV_6 = (CLK_HZ + 8 * 57600)  / (16 * 57600);
    localparam int DIV_7 = (CLK_HZ + 8 * 115200) / (16 * 115200);
    // The slowest rate has the largest divisor and sets the counter width.
    localparam int DW    = $clog2(DIV_0 + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    // Map a rate index onto its cycles-per-tick divisor.
    function automatic logic [DW-1:0] f_baud_div(input logic [2:0] sel);
        logic [DW-1:0] div;
        case (sel)
            3'd0:    div = DW'(DIV_0);
            3'd1:    div = DW'(DIV_1);
            3'd2:    div = DW'(DIV_2);
            3'd3:    div = DW'(DIV_3);
            3'd4:    div = DW'(DIV_4);
            3'd5:    div = DW'(DIV_5);
            3'd6:    div = DW'(DIV_6);
            default: div = DW'(DIV_7);
        endcase
        return div;
    endfunction

    // Even parity is the XOR of the data bits; odd parity is its inverse.
    function automatic logic f_parity(input logic [DATA_WIDTH-1:0] data, input logic [1:0] mode);
        return (^data) ^ (mode == 2'b10);
    endfunction

    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [LW-1:0]         r_level;
    logic                  r_full;
    logic                  r_empty;
    logic                  r_ovf;

    state_t                r_state;
    logic                  r_txd;
    logic                  r_busy;
    logic [DW-1:0]         r_div;
    logic [DW-1:0]         r_baud_cnt;
    logic [3:0]            r_tick_cnt;
    logic [2:0]            r_bit_cnt;
    logic                  r_stop_cnt;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_par_bit;
    logic                  r_par_en;
    logic                  r_two_stop;

    logic                  w_pop;
    logic                  w_push;
    logic                  w_drop;
    logic                  w_tick;
    logic                  w_bit_end;
    logic [LW-1:0]         w_level_nxt;

    // A frame starts (and the head is popped) only from IDLE with the transmitter enabled.
    assign w_pop     = (r_state == S_IDLE) && Tx_EN && !r_empty;
    // A full FIFO still accepts a word when the head leaves in the same cycle.
    assign w_push    = Tx_WR && Tx_EN && (!r_full || w_pop);
    assign w_drop    = Tx_WR && !w_push;
    assign w_tick    = (r_baud_cnt == (r_div - 1'b1));
    assign w_bit_end = w_tick && (r_tick_cnt == 4'd15);

    // Next occupancy: push and pop together leave the level unchanged.
    always_comb begin
        w_level_nxt = r_level;
        if (w_push && !w_pop) begin
            w_level_nxt = r_level + 1'b1;
        end else if (w_pop && !w_push) begin
            w_level_nxt = r_level - 1'b1;
        end else begin
            w_level_nxt = r_level;
        end
    end

    // FIFO storage; contents need no reset because the pointers define validity.
    always_ff @(posedge Clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= Tx_DATA;
        end
    end

    // FIFO pointers, occupancy flags and the dropped-write pulse.
    always_ff @(posedge Clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_level <= w_level_nxt;
            r_full  <= (w_level_nxt == LW'(FIFO_DEPTH));
            r_empty <= (w_level_nxt == LW'(0));
            r_ovf   <= w_drop;
        end
    end

    // Frame sequencer: baud timing, frame shadow registers and the registered line outputs.
    always_ff @(posedge Clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_txd      <= 1'b1;
            r_busy     <= 1'b0;
            r_div      <= '0;
            r_baud_cnt <= '0;
            r_tick_cnt <= 4'd0;
            r_bit_cnt  <= 3'd0;
            r_stop_cnt <= 1'b0;
            r_shift    <= '0;
            r_par_bit  <= 1'b0;
            r_par_en   <= 1'b0;
            r_two_stop <= 1'b0;
        end else begin
            // Counters rest at zero in IDLE so the start bit begins cycle-exact.
            if (r_state == S_IDLE) begin
                r_baud_cnt <= '0;
                r_tick_cnt <= 4'd0;
            end else if (w_tick) begin
                r_baud_cnt <= '0;
                r_tick_cnt <= r_tick_cnt + 4'd1;
            end else begin
                r_baud_cnt <= r_baud_cnt + 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_shift    <= r_mem[r_rd_ptr];
                        r_par_bit  <= f_parity(r_mem[r_rd_ptr], parity_mode);
                        r_par_en   <= (parity_mode == 2'b01) || (parity_mode == 2'b10);
                        r_two_stop <= two_stop;
                        r_div      <= f_baud_div(baud_select);
                        r_state    <= S_START;
                        r_txd      <= 1'b0;
                        r_busy     <= 1'b1;
                    end else begin
                        r_txd      <= 1'b1;
                        r_busy     <= 1'b0;
                    end
                end
                S_START: begin
                    if (w_bit_end) begin
                        r_state   <= S_DATA;
                        r_bit_cnt <= 3'd0;
                        r_txd     <= r_shift[0];
                        r_shift   <= r_shift >> 1;
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        if (r_bit_cnt == 3'(DATA_WIDTH - 1)) begin
                            r_stop_cnt <= 1'b0;
                            if (r_par_en) begin
                                r_state <= S_PARITY;
                                r_txd   <= r_par_bit;
                            end else begin
                                r_state <= S_STOP;
                                r_txd   <= 1'b1;
                            end
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            r_txd     <= r_shift[0];
                            r_shift   <= r_shift >> 1;
                        end
                    end
                end
                S_PARITY: begin
                    if (w_bit_end) begin
                        r_state <= S_STOP;
                        r_txd   <= 1'b1;
                    end
                end
                S_STOP: begin
                    if (w_bit_end) begin
                        if (r_two_stop && !r_stop_cnt) begin
                            r_stop_cnt <= 1'b1;
                        end else begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_txd   <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign TxD         = r_txd;
    assign Tx_BUSY     = r_busy;
    assign Tx_FULL     = r_full;
    assign Tx_EMPTY    = r_empty;
    assign Tx_LEVEL    = r_level;
    assign Tx_OVERFLOW = r_ovf;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed bench for uart_tx_fifo. Frames are checked at the
// centre of every bit against hand-written line sequences (first bit first),
// and frame length is checked by the exact cycles where Tx_BUSY rises and falls.
module tb_uart_tx_fifo;

    logic       Clk;
    logic       reset;
    logic [2:0] baud_select;
    logic [1:0] parity_mode;
    logic       two_stop;
    logic       Tx_EN;
    logic       Tx_WR;
    logic [7:0] Tx_DATA;
    logic       TxD;
    logic       Tx_BUSY;
    logic       Tx_FULL;
    logic       Tx_EMPTY;
    logic [3:0] Tx_LEVEL;
    logic       Tx_OVERFLOW;

    // Second instance: 5 data bits at 9600 baud.
    logic [2:0] b_sel;
    logic [1:0] b_par;
    logic       b_two;
    logic       b_en;
    logic       b_wr;
    logic [4:0] b_data;
    logic       b_txd;
    logic       b_busy;
    logic       b_full;
    logic       b_empty;
    logic [3:0] b_level;
    logic       b_ovf;

    int n_assert = 0;
    int n_fail   = 0;

    // Burst words 0x00,0x01,0x80,0xFF,0x55,0xAA,0x0F,0xF0,0x3C as 8N1 line sequences.
    logic [7:0] bw [9] = '{8'h00, 8'h01, 8'h80, 8'hFF, 8'h55, 8'hAA, 8'h0F, 8'hF0, 8'h3C};
    string      bx [9] = '{"0000000001", "0100000001", "0000000011", "0111111111",
                           "0101010101", "0010101011", "0111100001", "0000011111",
                           "0001111001"};

    uart_tx_fifo #(.CLK_HZ(50000000), .DATA_WIDTH(8), .FIFO_DEPTH(8)) dut (
        .Clk(Clk), .reset(reset), .baud_select(baud_select), .parity_mode(parity_mode),
        .two_stop(two_stop), .Tx_EN(Tx_EN), .Tx_WR(Tx_WR), .Tx_DATA(Tx_DATA),
        .TxD(TxD), .Tx_BUSY(Tx_BUSY), .Tx_FULL(Tx_FULL), .Tx_EMPTY(Tx_EMPTY),
        .Tx_LEVEL(Tx_LEVEL), .Tx_OVERFLOW(Tx_OVERFLOW)
    );

    uart_tx_fifo #(.CLK_HZ(50000000), .DATA_WIDTH(5), .FIFO_DEPTH(8)) dut5 (
        .Clk(Clk), .reset(reset), .baud_select(b_sel), .parity_mode(b_par),
        .two_stop(b_two), .Tx_EN(b_en), .Tx_WR(b_wr), .Tx_DATA(b_data),
        .TxD(b_txd), .Tx_BUSY(b_busy), .Tx_FULL(b_full), .Tx_EMPTY(b_empty),
        .Tx_LEVEL(b_level), .Tx_OVERFLOW(b_ovf)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Advance n rising edges and settle 1 time unit after the last one.
    task automatic tick(input int n);
        if (n > 0) begin
            repeat (n) @(posedge Clk);
            #1;
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic chkn(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Called at cycle (start-bit first cycle + off); returns at the first IDLE cycle after the frame.
    task automatic check_frame(input string tag, input bit sel5, input string bits,
                               input int blen, input int off);
        int n;
        int cur;
        int tgt;
        n   = bits.len();
        cur = off;
        if (off == 0) begin
            chk1({tag, " start edge"}, sel5 ? b_txd : TxD, 1'b0);
            chk1({tag, " busy rise"}, sel5 ? b_busy : Tx_BUSY, 1'b1);
        end
        for (int i = 0; i < n; i++) begin
            tgt = blen / 2 + i * blen;
            if (tgt >= cur) begin
                tick(tgt - cur);
                cur = tgt;
                chk1($sformatf("%s bit%0d", tag, i), sel5 ? b_txd : TxD, bits[i] == 8'h31);
            end
        end
        tick(n * blen - 1 - cur);
        chk1({tag, " busy last cycle"}, sel5 ? b_busy : Tx_BUSY, 1'b1);
        tick(1);
        chk1({tag, " busy fall"}, sel5 ? b_busy : Tx_BUSY, 1'b0);
        chk1({tag, " idle high"}, sel5 ? b_txd : TxD, 1'b1);
    endtask

    task automatic write_word(input logic [7:0] d);
        Tx_DATA = d;
        Tx_WR   = 1'b1;
        tick(1);
        Tx_WR   = 1'b0;
    endtask

    initial begin
        reset = 1'b1; baud_select = 3'd7; parity_mode = 2'b00; two_stop = 1'b0;
        Tx_EN = 1'b0; Tx_WR = 1'b0; Tx_DATA = 8'h00;
        b_sel = 3'd3; b_par = 2'b00; b_two = 1'b0; b_en = 1'b0; b_wr = 1'b0; b_data = 5'h00;
        tick(3);

        // Reset state
        chk1("rst TxD", TxD, 1'b1);
        chk1("rst busy", Tx_BUSY, 1'b0);
        chk1("rst full", Tx_FULL, 1'b0);
        chk1("rst empty", Tx_EMPTY, 1'b1);
        chkn("rst level", 32'(Tx_LEVEL), 32'd0);
        chk1("rst ovf", Tx_OVERFLOW, 1'b0);
        reset = 1'b0;
        tick(2);

        // 8N1 0x8A: pop one cycle after the write, start bit the cycle after that
        Tx_EN = 1'b1;
        write_word(8'h8A);
        chk1("8n1 pre TxD", TxD, 1'b1);
        chk1("8n1 pre busy", Tx_BUSY, 1'b0);
        chkn("8n1 pre level", 32'(Tx_LEVEL), 32'd1);
        tick(1);
        chkn("8n1 popped level", 32'(Tx_LEVEL), 32'd0);
        check_frame("8n1 8A", 1'b0, "0010100011", 432, 0);

        // Even parity 0x8A; config changed right after frame start must not affect it
        parity_mode = 2'b01;
        write_word(8'h8A);
        tick(1);
        parity_mode = 2'b10; two_stop = 1'b1; baud_select = 3'd0;
        check_frame("8E1 8A", 1'b0, "00101000111", 432, 0);

        // Odd parity, two stop bits: 12 bits = 5184 cycles
        baud_select = 3'd7;
        write_word(8'h8A);
        tick(1);
        check_frame("8O2 8A", 1'b0, "001010001011", 432, 0);
        parity_mode = 2'b00; two_stop = 1'b0;

        // Burst on the 8-bit unit in parallel with the 5-bit unit's frame
        fork
            begin
                for (int i = 0; i < 9; i++) begin
                    Tx_DATA = bw[i];
                    Tx_WR   = 1'b1;
                    tick(1);
                    chkn($sformatf("burst level w%0d", i), 32'(Tx_LEVEL), (i == 0) ? 32'd1 : 32'(i));
                    chk1($sformatf("burst full w%0d", i), Tx_FULL, i == 8);
                    chk1($sformatf("burst ovf w%0d", i), Tx_OVERFLOW, 1'b0);
                end
                chk1("burst busy", Tx_BUSY, 1'b1);
                Tx_DATA = 8'h99;
                tick(1);
                Tx_WR = 1'b0;
                chk1("burst ovf pulse", Tx_OVERFLOW, 1'b1);
                chkn("burst level after drop", 32'(Tx_LEVEL), 32'd8);
                tick(1);
                chk1("burst ovf clears", Tx_OVERFLOW, 1'b0);
                for (int i = 0; i < 9; i++) begin
                    if (i > 0) begin
                        tick(1);
                    end
                    check_frame($sformatf("burst f%0d", i), 1'b0, bx[i], 432, (i == 0) ? 9 : 0);
                    chkn($sformatf("burst level f%0d", i), 32'(Tx_LEVEL), 32'(8 - i));
                end
                chk1("burst drained empty", Tx_EMPTY, 1'b1);
            end
            begin
                b_en   = 1'b1;
                b_data = 5'h15;
                b_wr   = 1'b1;
                tick(1);
                b_wr   = 1'b0;
                chkn("w5 level", 32'(b_level), 32'd1);
                tick(1);
                check_frame("w5 15", 1'b1, "0101011", 5216, 0);
                chk1("w5 empty", b_empty, 1'b1);
            end
        join

        // Tx_EN dropped mid-DATA: frame completes, queued word held until re-enabled
        write_word(8'hFF);
        write_word(8'h11);
        chkn("en queued level", 32'(Tx_LEVEL), 32'd1);
        chk1("en start", TxD, 1'b0);
        tick(1000);
        Tx_EN = 1'b0;
        check_frame("en FF", 1'b0, "0111111111", 432, 1000);
        chkn("en held level", 32'(Tx_LEVEL), 32'd1);
        write_word(8'h22);
        chk1("en off write ovf", Tx_OVERFLOW, 1'b1);
        chkn("en off write level", 32'(Tx_LEVEL), 32'd1);
        tick(50);
        chk1("en off busy", Tx_BUSY, 1'b0);
        chk1("en off TxD", TxD, 1'b1);
        chkn("en off level", 32'(Tx_LEVEL), 32'd1);
        Tx_EN = 1'b1;
        tick(1);
        check_frame("en 11", 1'b0, "0100010001", 432, 0);

        // Reset during the (odd, =0) parity bit, then a clean frame
        parity_mode = 2'b10;
        write_word(8'h8A);
        write_word(8'h33);
        tick(4104);
        chk1("mid parity bit", TxD, 1'b0);
        chk1("mid busy", Tx_BUSY, 1'b1);
        chkn("mid level", 32'(Tx_LEVEL), 32'd1);
        reset = 1'b1;
        tick(1);
        chk1("mid rst TxD", TxD, 1'b1);
        chk1("mid rst busy", Tx_BUSY, 1'b0);
        chkn("mid rst level", 32'(Tx_LEVEL), 32'd0);
        chk1("mid rst empty", Tx_EMPTY, 1'b1);
        reset = 1'b0;
        parity_mode = 2'b00;
        tick(2);
        write_word(8'h3C);
        chk1("post rst pre TxD", TxD, 1'b1);
        tick(1);
        check_frame("post rst 3C", 1'b0, "0001111001", 432, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised, FIFO-buffered UART transmitter. It is the next generation of the fixed 8-bit transmitter in the UART_communication design.
- Adds configurable data width, buffering depth, runtime parity mode and 1/2 stop bits.
- Sits between the host write port and the serial line TxD.
- Uses the same 8-entry baud_select table and 16x baud-tick scheme as the existing receiver, so both ends share a timebase.

Parameters:
CLK_HZ, 50000000, system clock frequency in Hz; used to compute the baud divisor table.
DATA_WIDTH, 8, data bits per frame; legal range 5..8.
FIFO_DEPTH, 8, transmit FIFO entries; power of two, 2..64.

Ports:
Clk  input  1  system clock; all logic on rising edge.
reset  input  1  synchronous, active-high reset.
baud_select  input  3  rate index: 0=300, 1=1200, 2=4800, 3=9600, 4=19200, 5=38400, 6=57600, 7=115200 baud.
parity_mode  input  2  00=none, 01=even, 10=odd, 11=none (reserved).
two_stop  input  1  1 = two stop bits, 0 = one stop bit.
Tx_EN  input  1  transmitter enable; gates both FIFO writes and frame starts.
Tx_WR  input  1  single-cycle write strobe.
Tx_DATA  input  DATA_WIDTH  word to enqueue.
TxD  output  1  serial line; registered output, idles high.
Tx_BUSY  output  1  high while a frame is on the line.
Tx_FULL  output  1  FIFO holds FIFO_DEPTH words.
Tx_EMPTY  output  1  FIFO holds 0 words.
Tx_LEVEL  output  clog2(FIFO_DEPTH)+1  current FIFO occupancy.
Tx_OVERFLOW  output  1  one-cycle pulse when a write is dropped.

Behaviour:
- Reset values: TxD=1, Tx_BUSY=0, Tx_FULL=0, Tx_EMPTY=1, Tx_LEVEL=0, Tx_OVERFLOW=0.
  - Reset clears the FIFO pointers and the baud counter, and forces the FSM to IDLE.
  - Reset asserted mid-frame: TxD=1 on the next edge; the partial frame is abandoned.
- Baud tick: divisor D = round(CLK_HZ / (16 * rate)).
  - A tick fires every D cycles.
  - One bit lasts 16 ticks = 16*D cycles. At 50 MHz with select 7, D=27, so one bit = 432 cycles.
  - The counter restarts at 0 on the cycle a frame starts, so the start-bit edge is cycle-exact.
- FIFO write: Tx_WR=1 and Tx_EN=1 and (not full, or a pop occurs in the same cycle) -> the word is enqueued.
  - Tx_WR=1 while full with no pop, or Tx_WR=1 with Tx_EN=0 -> word dropped, Tx_OVERFLOW=1 for one cycle.
  - Simultaneous push and pop: Tx_LEVEL unchanged. Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: TxD=1. If Tx_EN=1 and FIFO not empty: pop the head; latch the word, parity_mode, two_stop and baud_select into a frame shadow; go to START.
  - START: TxD=0 for one bit, then DATA.
  - DATA: transmit DATA_WIDTH bits LSB first, one bit each. Then go to PARITY if the latched mode is even/odd, else STOP.
  - PARITY: even -> XOR of the data bits; odd -> its inverse. One bit, then STOP.
  - STOP: TxD=1 for one bit, or two bits if two_stop was latched. Then IDLE, which may start the next frame on the following cycle. Back-to-back frames have no extra idle gap beyond one cycle.
- Latency: write at cycle N into an empty FIFO with IDLE and Tx_EN=1 -> pop at N+1, TxD falls at N+2.
- Config changes mid-frame (baud_select, parity_mode, two_stop) have no effect until the next frame start.
- Tx_EN deasserted mid-frame: the current frame completes; no new frame starts; FIFO contents are retained.
- Tx_BUSY = (state != IDLE). It is registered and aligned with TxD.

Test Plan:
- 8N1, select 7, write 0x8A -> TxD: 0, 0,1,0,1,0,0,0,1, 1, each bit 432 cycles. Tx_BUSY high for 4320 cycles.
- Even parity, 0x8A -> parity bit 1. Odd parity -> parity bit 0. Odd parity with two_stop=1 -> frame of 12 bits = 5184 cycles.
- Burst of 9 writes, DEPTH 8, while a frame is in flight -> first word popped at once. The remaining 8 fill the FIFO: Tx_FULL=1, Tx_LEVEL=8, no overflow. A 10th write -> Tx_OVERFLOW pulse; transmitted order matches write order.
- Write 0xFF, then drop Tx_EN mid-DATA -> frame finishes intact. A queued 0x11 stays queued (Tx_LEVEL=1) until Tx_EN returns, then transmits.
- Assert reset during the PARITY bit -> next cycle TxD=1, Tx_LEVEL=0, Tx_BUSY=0. A new write then transmits correctly.
- DATA_WIDTH=5, select 3 (D=326, 5216 cycles/bit), write 0x15 -> TxD: 0,1,0,1,0,1,1. Upper Tx_DATA bits are ignored.
